// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with occupancy, threshold flags and registered read data.
// Define FIFO_ERROR_EN to build the sticky overflow/underflow flags; otherwise they read 0.
module fifo_param #(
    parameter int DATA_WIDTH = 10,
    parameter int DEPTH      = 8,
    parameter int AE_THRESH  = 2,
    parameter int AF_THRESH  = 6
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  logic                         pop,
    input  logic [DATA_WIDTH-1:0]        data_in,
    output logic [DATA_WIDTH-1:0]        data_out,
    output logic                         valid_out,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty,
    output logic                         almost_full,
    output logic                         almost_empty,
    output logic                         overflow,
    output logic                         underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic [CW-1:0]         count_p1;
    logic [DATA_WIDTH-1:0] rd_data_p1;
    logic                  vld_p1;
    logic                  push_acc;
    logic                  pop_acc;

    // Stage p0: accept decisions from registered state only
    assign full     = (count_p1 == DEPTH_C);
    assign empty    = (count_p1 == '0);
    assign push_acc = push && (!full || pop);
    assign pop_acc  = pop && !empty;

    // Storage is deliberately not reset; valid data is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // Stage p1: pointers, occupancy and registered read port
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_p1   <= '0;
            rd_data_p1 <= '0;
            vld_p1     <= 1'b0;
        end else begin
            vld_p1 <= pop_acc;
            if (push_acc) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_acc) begin
                rd_ptr     <= rd_ptr + PW'(1);
                rd_data_p1 <= mem[rd_ptr];
            end
            case ({push_acc, pop_acc})
                2'b10:   count_p1 <= count_p1 + CW'(1);
                2'b01:   count_p1 <= count_p1 - CW'(1);
                default: count_p1 <= count_p1;
            endcase
        end
    end

    assign count        = count_p1;
    assign data_out     = rd_data_p1;
    assign valid_out    = vld_p1;
    assign almost_full  = (count_p1 >= AF_C);
    assign almost_empty = (count_p1 <= AE_C);

`ifdef FIFO_ERROR_EN
    logic ovf_p1;
    logic udf_p1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_p1 <= 1'b0;
            udf_p1 <= 1'b0;
        end else begin
            if (push && full && !pop) begin
                ovf_p1 <= 1'b1;
            end
            if (pop && empty) begin
                udf_p1 <= 1'b1;
            end
        end
    end

    assign overflow  = ovf_p1;
    assign underflow = udf_p1;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Directed self-checking bench for fifo_param at default parameters.
module tb_fifo_param;

    localparam int DW = 10;
    localparam int CW = 4;
`ifdef FIFO_ERROR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic [CW-1:0] count;
    logic          full, empty, almost_full, almost_empty, overflow, underflow;

    int checks = 0;
    int errors = 0;

    fifo_param dut (
        .clk(clk), .reset(reset), .push(push), .pop(pop), .data_in(data_in),
        .data_out(data_out), .valid_out(valid_out), .count(count),
        .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    // Apply current inputs across one rising edge and sample 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        checks++; if (count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
        checks++; if (empty !== 1'b1 || almost_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b%b exp 11", empty, almost_empty); end
        checks++; if (full !== 1'b0 || almost_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b%b exp 00", full, almost_full); end
        checks++; if (data_out !== 10'h000 || valid_out !== 1'b0) begin errors++; $display("FAIL reset_data got %h/%b exp 000/0", data_out, valid_out); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL reset_err got %b%b exp 00", overflow, underflow); end
        @(negedge clk);
        reset = 1'b1;
        step();
        checks++; if (count !== 4'd0 || empty !== 1'b1 || valid_out !== 1'b0) begin errors++; $display("FAIL idle got cnt %0d empty %b vld %b exp 0 1 0", count, empty, valid_out); end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 8; i++) begin
            push = 1'b1; data_in = DW'(i);
            step();
            checks++; if (count !== CW'(i)) begin errors++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, count, i); end
            checks++; if (almost_full !== (i >= 6) || full !== (i == 8)) begin errors++; $display("FAIL fill_hi[%0d] got af %b full %b exp %b %b", i, almost_full, full, i >= 6, i == 8); end
            checks++; if (almost_empty !== (i <= 2) || empty !== 1'b0) begin errors++; $display("FAIL fill_lo[%0d] got ae %b empty %b exp %b 0", i, almost_empty, empty, i <= 2); end
        end
        push = 1'b0;
    endtask

    task automatic test_overflow();
        push = 1'b1; data_in = 10'h3FF;
        step();
        push = 1'b0;
        checks++; if (count !== 4'd8 || full !== 1'b1) begin errors++; $display("FAIL ovf_count got %0d/%b exp 8/1", count, full); end
        checks++; if (overflow !== ERR_EN) begin errors++; $display("FAIL ovf_flag got %b exp %b", overflow, ERR_EN); end
        step();
        checks++; if (overflow !== ERR_EN || valid_out !== 1'b0) begin errors++; $display("FAIL ovf_sticky got %b/%b exp %b/0", overflow, valid_out, ERR_EN); end
    endtask

    task automatic test_push_pop_full();
        for (int i = 1; i <= 8; i++) begin
            push = 1'b1; pop = 1'b1; data_in = 10'h2AA;
            step();
            checks++; if (data_out !== DW'(i) || valid_out !== 1'b1) begin errors++; $display("FAIL pp_full_data[%0d] got %h/%b exp %h/1", i, data_out, valid_out, DW'(i)); end
            checks++; if (count !== 4'd8 || full !== 1'b1) begin errors++; $display("FAIL pp_full_count[%0d] got %0d exp 8", i, count); end
        end
        push = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            pop = 1'b1;
            step();
            checks++; if (data_out !== 10'h2AA || valid_out !== 1'b1) begin errors++; $display("FAIL drain_2aa[%0d] got %h/%b exp 2aa/1", i, data_out, valid_out); end
            checks++; if (count !== CW'(8 - i)) begin errors++; $display("FAIL drain_count[%0d] got %0d exp %0d", i, count, 8 - i); end
        end
        pop = 1'b0;
        step();
        checks++; if (empty !== 1'b1 || valid_out !== 1'b0 || data_out !== 10'h2AA) begin errors++; $display("FAIL drained got e %b v %b d %h exp 1 0 2aa", empty, valid_out, data_out); end
        checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL udf_early got %b exp 0", underflow); end
    endtask

    task automatic test_empty_push_pop();
        push = 1'b1; pop = 1'b1; data_in = 10'h155;
        step();
        push = 1'b0; pop = 1'b0;
        checks++; if (count !== 4'd1 || empty !== 1'b0) begin errors++; $display("FAIL epp_count got %0d exp 1", count); end
        checks++; if (valid_out !== 1'b0 || data_out !== 10'h2AA) begin errors++; $display("FAIL epp_nobypass got %h/%b exp 2aa/0", data_out, valid_out); end
        checks++; if (underflow !== ERR_EN) begin errors++; $display("FAIL udf_flag got %b exp %b", underflow, ERR_EN); end
        pop = 1'b1;
        step();
        pop = 1'b0;
        checks++; if (data_out !== 10'h155 || valid_out !== 1'b1 || count !== 4'd0) begin errors++; $display("FAIL epp_pop got %h/%b/%0d exp 155/1/0", data_out, valid_out, count); end
        checks++; if (underflow !== ERR_EN || overflow !== ERR_EN) begin errors++; $display("FAIL err_sticky got %b%b exp %b%b", overflow, underflow, ERR_EN, ERR_EN); end
    endtask

    task automatic test_wrap_and_reset();
        for (int i = 0; i < 5; i++) begin
            push = 1'b1; data_in = DW'(10'h010 + i);
            step();
        end
        push = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pop = 1'b1;
            step();
            checks++; if (data_out !== DW'(10'h010 + i) || valid_out !== 1'b1) begin errors++; $display("FAIL wrap_pop[%0d] got %h exp %h", i, data_out, DW'(10'h010 + i)); end
        end
        pop = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push = 1'b1; data_in = DW'(10'h020 + i);
            step();
        end
        push = 1'b0;
        checks++; if (count !== 4'd8 || full !== 1'b1) begin errors++; $display("FAIL wrap_full got %0d exp 8", count); end
        pop = 1'b1;
        step();
        checks++; if (data_out !== 10'h013) begin errors++; $display("FAIL wrap_d0 got %h exp 013", data_out); end
        step();
        checks++; if (data_out !== 10'h014) begin errors++; $display("FAIL wrap_d1 got %h exp 014", data_out); end
        step();
        checks++; if (data_out !== 10'h020) begin errors++; $display("FAIL wrap_d2 got %h exp 020", data_out); end
        step();
        checks++; if (data_out !== 10'h021 || count !== 4'd4) begin errors++; $display("FAIL wrap_d3 got %h/%0d exp 021/4", data_out, count); end
        pop = 1'b0;
        // asynchronous reset between edges must clear state without a clock
        reset = 1'b0;
        #1;
        checks++; if (count !== 4'd0 || empty !== 1'b1 || almost_empty !== 1'b1) begin errors++; $display("FAIL midrst_count got %0d/%b exp 0/1", count, empty); end
        checks++; if (data_out !== 10'h000 || valid_out !== 1'b0 || full !== 1'b0 || almost_full !== 1'b0) begin errors++; $display("FAIL midrst_out got %h/%b exp 000/0", data_out, valid_out); end
        checks++; if (overflow !== 1'b0 || underflow !== 1'b0) begin errors++; $display("FAIL midrst_err got %b%b exp 00", overflow, underflow); end
        @(negedge clk);
        reset = 1'b1;
        push = 1'b1; data_in = 10'h0AB;
        step();
        push = 1'b0; pop = 1'b1;
        step();
        pop = 1'b0;
        checks++; if (data_out !== 10'h0AB || count !== 4'd0) begin errors++; $display("FAIL post_rst got %h/%0d exp 0ab/0", data_out, count); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_push_pop_full();
        test_empty_push_pop();
        test_wrap_and_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
